// File: rtl/mapas_pkg.sv
// Shared types for the occupancy-grid ray mapper: cell codes, headings, FSM states
// and the sensor-to-heading offsets.
package mapas_pkg;

  typedef enum logic [1:0] {
    DESCONHECIDA = 2'd0,
    LIVRE        = 2'd1,
    PAREDE       = 2'd2,
    VISITADA     = 2'd3
  } celula_t;

  // 0 = +Y, 1 = +X, 2 = -Y, 3 = -X
  typedef logic [1:0] direcao_t;

  typedef enum logic [2:0] {
    OCIOSO,
    ROBO,
    SEL,
    RAIO,
    FIM
  } estado_t;

  localparam direcao_t OFS_FRENTE  = 2'd0;
  localparam direcao_t OFS_DIREITA = 2'd1;
  localparam direcao_t OFS_TRAS    = 2'd2;
  localparam direcao_t OFS_ESQUERDA = 2'd3;

  // Sensor index follows the scan order frente, direita, tras, esquerda.
  function automatic direcao_t direcao_absoluta(input direcao_t rumo, input logic [1:0] sensor);
    direcao_t ofs;
    case (sensor)
      2'd0:    ofs = OFS_FRENTE;
      2'd1:    ofs = OFS_DIREITA;
      2'd2:    ofs = OFS_TRAS;
      default: ofs = OFS_ESQUERDA;
    endcase
    return direcao_t'(rumo + ofs);
  endfunction

endpackage

// File: rtl/mapas_passo.sv
// Combinational ray step: the cell k steps away from the base along a heading,
// plus whether it lands inside the grid.
module mapas_passo
  import mapas_pkg::*;
#(
  parameter int unsigned TamanhoMalha     = 8,
  parameter int unsigned tamanhoDistancia = 4,
  localparam int unsigned IW = $clog2(TamanhoMalha)
) (
  input  logic [tamanhoDistancia-1:0] base_x_i,
  input  logic [tamanhoDistancia-1:0] base_y_i,
  input  direcao_t                    dir_i,
  input  logic [tamanhoDistancia-1:0] passo_i,
  output logic [IW-1:0]               alvo_x_o,
  output logic [IW-1:0]               alvo_y_o,
  output logic                        dentro_o
);

  localparam int unsigned W = tamanhoDistancia;

  logic signed [W:0] base_x_s, base_y_s, passo_s, alvo_x_s, alvo_y_s;

  // Sums that overflow the positive range wrap negative, which still reads as out of grid.
  function automatic logic na_malha(input logic signed [W:0] c);
    return !c[W] && (32'(c[W-1:0]) < 32'(TamanhoMalha));
  endfunction

  always_comb begin
    base_x_s = $signed({1'b0, base_x_i});
    base_y_s = $signed({1'b0, base_y_i});
    passo_s  = $signed({1'b0, passo_i});
    alvo_x_s = base_x_s;
    alvo_y_s = base_y_s;
    case (dir_i)
      2'd0:    alvo_y_s = base_y_s + passo_s;
      2'd1:    alvo_x_s = base_x_s + passo_s;
      2'd2:    alvo_y_s = base_y_s - passo_s;
      default: alvo_x_s = base_x_s - passo_s;
    endcase
  end

  assign alvo_x_o = alvo_x_s[IW-1:0];
  assign alvo_y_o = alvo_y_s[IW-1:0];
  assign dentro_o = na_malha(alvo_x_s) && na_malha(alvo_y_s);

endmodule

// File: rtl/mapas_raios.sv
// Occupancy-grid mapper: latches a pose plus four range readings and ray-marches
// each beam through the grid, one cell write per cycle.
module mapas_raios
  import mapas_pkg::*;
#(
  parameter int unsigned TamanhoMalha     = 8,
  parameter int unsigned tamanhoDistancia = 4,
  parameter int unsigned LivrePrevalece   = 0
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [tamanhoDistancia-1:0]                posicaoAtualnoEixoX,
  input  logic [tamanhoDistancia-1:0]                posicaoAtualnoEixoY,
  input  logic [1:0]                                 direcaoAtual,
  input  logic [tamanhoDistancia-1:0]                distanciaFrente,
  input  logic [tamanhoDistancia-1:0]                distanciaDireita,
  input  logic [tamanhoDistancia-1:0]                distanciaTras,
  input  logic [tamanhoDistancia-1:0]                distanciaEsquerda,
  input  logic                                       novoDado,
  input  logic                                       limparMalha,
  output logic                                       pronto,
  output logic [TamanhoMalha-1:0][TamanhoMalha-1:0][1:0] malha,
  output logic                                       operacaoFinalizada,
  output logic                                       erroPosicao
);

  localparam int unsigned W  = tamanhoDistancia;
  localparam int unsigned IW = $clog2(TamanhoMalha);
  localparam logic [W-1:0] SEM_ECO = '1;

  estado_t           estado_q, estado_d;
  logic [W-1:0]      x_q, x_d, y_q, y_d;
  direcao_t          rumo_q, rumo_d;
  logic [3:0][W-1:0] dist_q, dist_d;
  logic [1:0]        sensor_q, sensor_d;
  logic [W-1:0]      passo_q, passo_d;
  logic              pronto_q, pronto_d;
  logic              fin_q, fin_d;
  logic              erro_q, erro_d;
  logic [TamanhoMalha-1:0][TamanhoMalha-1:0][1:0] malha_q;

  logic              escreve_c, limpa_c, dentro_c;
  logic [IW-1:0]     esc_x_c, esc_y_c, alvo_x_c, alvo_y_c;
  celula_t           esc_val_c, atual_c;
  logic [W-1:0]      dist_sel_c;
  direcao_t          dir_raio_c;
  logic              pose_ok_c;

  assign dist_sel_c = dist_q[sensor_q];
  assign dir_raio_c = direcao_absoluta(rumo_q, sensor_q);
  assign pose_ok_c  = (32'(x_q) < 32'(TamanhoMalha)) && (32'(y_q) < 32'(TamanhoMalha));
  assign atual_c    = celula_t'(malha_q[alvo_x_c][alvo_y_c]);

  mapas_passo #(
    .TamanhoMalha    (TamanhoMalha),
    .tamanhoDistancia(tamanhoDistancia)
  ) u_passo (
    .base_x_i(x_q),
    .base_y_i(y_q),
    .dir_i   (dir_raio_c),
    .passo_i (passo_q),
    .alvo_x_o(alvo_x_c),
    .alvo_y_o(alvo_y_c),
    .dentro_o(dentro_c)
  );

  // Next-state, latch updates and the single grid write of the cycle.
  always_comb begin
    estado_d  = estado_q;
    x_d       = x_q;
    y_d       = y_q;
    rumo_d    = rumo_q;
    dist_d    = dist_q;
    sensor_d  = sensor_q;
    passo_d   = passo_q;
    pronto_d  = pronto_q;
    fin_d     = fin_q;
    erro_d    = erro_q;
    escreve_c = 1'b0;
    limpa_c   = 1'b0;
    esc_x_c   = x_q[IW-1:0];
    esc_y_c   = y_q[IW-1:0];
    esc_val_c = VISITADA;

    case (estado_q)
      OCIOSO: begin
        if (limparMalha) begin
          limpa_c = 1'b1;
        end else if (novoDado) begin
          x_d      = posicaoAtualnoEixoX;
          y_d      = posicaoAtualnoEixoY;
          rumo_d   = direcaoAtual;
          dist_d   = {distanciaEsquerda, distanciaTras, distanciaDireita, distanciaFrente};
          pronto_d = 1'b0;
          fin_d    = 1'b0;
          erro_d   = 1'b0;
          estado_d = ROBO;
        end
      end
      ROBO: begin
        if (!pose_ok_c) begin
          erro_d   = 1'b1;
          estado_d = FIM;
        end else begin
          escreve_c = 1'b1;
          sensor_d  = 2'd0;
          estado_d  = SEL;
        end
      end
      SEL: begin
        if (dist_sel_c != '0) begin
          passo_d  = W'(1);
          estado_d = RAIO;
        end else if (sensor_q == 2'd3) begin
          estado_d = FIM;
        end else begin
          sensor_d = sensor_q + 2'd1;
        end
      end
      RAIO: begin
        if (dentro_c) begin
          esc_x_c = alvo_x_c;
          esc_y_c = alvo_y_c;
          // Terminal cell of a real echo is a wall; everything else along the beam is free.
          if (passo_q == dist_sel_c && dist_sel_c != SEM_ECO) begin
            esc_val_c = PAREDE;
            escreve_c = (atual_c == DESCONHECIDA) || (atual_c == LIVRE);
          end else begin
            esc_val_c = LIVRE;
            escreve_c = (atual_c == DESCONHECIDA) ||
                        ((LivrePrevalece != 0) && (atual_c == PAREDE));
          end
        end
        if (!dentro_c || passo_q == dist_sel_c) begin
          if (sensor_q == 2'd3) begin
            estado_d = FIM;
          end else begin
            sensor_d = sensor_q + 2'd1;
            estado_d = SEL;
          end
        end else begin
          passo_d = W'(passo_q + 1'b1);
        end
      end
      FIM: begin
        pronto_d = 1'b1;
        fin_d    = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= OCIOSO;
      x_q      <= '0;
      y_q      <= '0;
      rumo_q   <= '0;
      dist_q   <= '0;
      sensor_q <= '0;
      passo_q  <= '0;
      pronto_q <= 1'b1;
      fin_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      x_q      <= x_d;
      y_q      <= y_d;
      rumo_q   <= rumo_d;
      dist_q   <= dist_d;
      sensor_q <= sensor_d;
      passo_q  <= passo_d;
      pronto_q <= pronto_d;
      fin_q    <= fin_d;
      erro_q   <= erro_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || limpa_c) begin
      malha_q <= '0;
    end else if (escreve_c) begin
      malha_q[esc_x_c][esc_y_c] <= esc_val_c;
    end
  end

  assign pronto             = pronto_q;
  assign operacaoFinalizada = fin_q;
  assign erroPosicao        = erro_q;
  assign malha              = malha_q;

endmodule
